// File: rtl/jtkcpu_pshpul_pkg.sv
// Shared encodings for the KCPU stack push/pull sequencer: FSM states and
// register-mask bit positions (PC highest, CC lowest).
package jtkcpu_pshpul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PSH_DEC = 3'd1,
    ST_PSH_WR  = 3'd2,
    ST_PUL_RD  = 3'd3,
    ST_PUL_LD  = 3'd4,
    ST_DONE    = 3'd5
  } pshpul_state_t;

  localparam int STK_PC = 7;
  localparam int STK_US = 6;
  localparam int STK_Y  = 5;
  localparam int STK_X  = 4;
  localparam int STK_DP = 3;
  localparam int STK_B  = 2;
  localparam int STK_A  = 1;
  localparam int STK_CC = 0;

endpackage

// File: rtl/jtkcpu_prienc.sv
// Picks the highest (push) or lowest (pull) set mask bit as a one-hot vector and
// flags whether it names a 16-bit register. Purely combinational, no handshake.
module jtkcpu_prienc
  import jtkcpu_pshpul_pkg::*;
(
  input  logic [7:0] bits,
  input  logic       lowest,
  output logic [7:0] onehot,
  output logic       wide
);

  always_comb begin
    onehot = '0;
    if (lowest) begin
      onehot = bits & (~bits + 8'd1);
    end else begin
      // ascending scan: the last hit is the highest set bit
      for (int i = 0; i < 8; i++) begin
        if (bits[i]) begin
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end
    wide = |onehot[STK_PC:STK_X];
  end

endmodule

// File: rtl/jtkcpu_pshpul.sv
// Byte-by-byte stack push/pull sequencer; first strobe 1 cen cycle after start,
// 2 cen cycles per byte plus DONE. Bus phases hold their request until mem_rdy.
module jtkcpu_pshpul
  import jtkcpu_pshpul_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       start_psh,
  input  logic       start_pul,
  input  logic       ussel_in,
  input  logic [7:0] mask,
  input  logic       mem_rdy,
  output logic [7:0] psh_sel,
  output logic       psh_hihalf,
  output logic       psh_ussel,
  output logic       psh_dec,
  output logic       pul_en,
  output logic       stack_busy,
  output logic       mem_we,
  output logic       mem_rd,
  output logic       busy,
  output logic       done
);

  pshpul_state_t st, st_nx;
  logic [7:0]    sel, sel_nx;
  logic          half, half_nx;   // first byte of the current 16-bit register done
  logic          ussel, ussel_nx;
  logic          pul_dir, pul_dir_nx;
  logic [7:0]    cur;
  logic          cur_wide;

  jtkcpu_prienc u_prienc (
    .bits   (sel),
    .lowest (pul_dir),
    .onehot (cur),
    .wide   (cur_wide)
  );

  always_comb begin
    st_nx      = st;
    sel_nx     = sel;
    half_nx    = half;
    ussel_nx   = ussel;
    pul_dir_nx = pul_dir;
    case (st)
      ST_IDLE: begin
        if (start_psh || start_pul) begin
          sel_nx     = mask;
          ussel_nx   = ussel_in;
          half_nx    = 1'b0;
          pul_dir_nx = !start_psh;
          if (mask == 8'd0)   st_nx = ST_DONE;
          else if (start_psh) st_nx = ST_PSH_DEC;
          else                st_nx = ST_PUL_RD;
        end
      end
      ST_PSH_DEC: st_nx = ST_PSH_WR;
      ST_PSH_WR: begin
        if (mem_rdy) begin
          if (cur_wide && !half) begin
            half_nx = 1'b1;
            st_nx   = ST_PSH_DEC;
          end else begin
            sel_nx  = sel & ~cur;
            half_nx = 1'b0;
            st_nx   = ((sel & ~cur) == 8'd0) ? ST_DONE : ST_PSH_DEC;
          end
        end
      end
      ST_PUL_RD: begin
        if (mem_rdy) st_nx = ST_PUL_LD;
      end
      ST_PUL_LD: begin
        if (cur_wide && !half) begin
          half_nx = 1'b1;
          st_nx   = ST_PUL_RD;
        end else begin
          sel_nx  = sel & ~cur;
          half_nx = 1'b0;
          st_nx   = ((sel & ~cur) == 8'd0) ? ST_DONE : ST_PUL_RD;
        end
      end
      ST_DONE: begin
        sel_nx = 8'd0;
        st_nx  = ST_IDLE;
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_IDLE;
      sel     <= 8'd0;
      half    <= 1'b0;
      ussel   <= 1'b0;
      pul_dir <= 1'b0;
    end else if (cen) begin
      st      <= st_nx;
      sel     <= sel_nx;
      half    <= half_nx;
      ussel   <= ussel_nx;
      pul_dir <= pul_dir_nx;
    end
  end

  // pushes go low byte then high; pulls go high byte then low
  assign psh_hihalf = pul_dir ? (cur_wide && !half) : half;
  assign psh_sel    = (st == ST_DONE) ? 8'd0 : sel;
  assign psh_ussel  = ussel;
  assign psh_dec    = (st == ST_PSH_DEC);
  assign mem_we     = (st == ST_PSH_WR);
  assign mem_rd     = (st == ST_PUL_RD);
  assign pul_en     = (st == ST_PUL_LD);
  assign stack_busy = (st == ST_PUL_LD);
  assign busy       = (st != ST_IDLE);
  assign done       = (st == ST_DONE);

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
// Scoreboard bench for jtkcpu_pshpul: per-cycle expected outputs are queued when
// an operation is launched and compared one entry per clock afterwards.
module tb_jtkcpu_pshpul;

  logic       clk = 1'b0;
  logic       rst_n, cen, start_psh, start_pul, ussel_in, mem_rdy;
  logic [7:0] mask;
  logic [7:0] psh_sel;
  logic       psh_hihalf, psh_ussel, psh_dec, pul_en, stack_busy;
  logic       mem_we, mem_rd, busy, done;

  jtkcpu_pshpul dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .start_psh  (start_psh),
    .start_pul  (start_pul),
    .ussel_in   (ussel_in),
    .mask       (mask),
    .mem_rdy    (mem_rdy),
    .psh_sel    (psh_sel),
    .psh_hihalf (psh_hihalf),
    .psh_ussel  (psh_ussel),
    .psh_dec    (psh_dec),
    .pul_en     (pul_en),
    .stack_busy (stack_busy),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;   // mem_rdy to drive for the following edge
    logic       cen;   // cen to drive for the following edge
    logic [7:0] sel;
    logic       hh, us, dec, pen, sb, we, rd, bsy, dn;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   nadd = 0;
  int   freeze_idx = -1;
  logic noise = 1'b0;

  wire [16:0] obs = {psh_sel, psh_hihalf, psh_ussel, psh_dec, pul_en, stack_busy,
                     mem_we, mem_rd, busy, done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [7:0] sel, input logic hh, input logic us,
                              input logic dec, input logic pen, input logic we,
                              input logic rd, input logic bsy, input logic dn,
                              input logic rdy);
    ent_t e;
    e.rdy = rdy; e.cen = 1'b1; e.sel = sel; e.hh = hh; e.us = us; e.dec = dec;
    e.pen = pen; e.sb = pen; e.we = we; e.rd = rd; e.bsy = bsy; e.dn = dn;
    return e;
  endfunction

  task automatic add(input ent_t e);
    ent_t f;
    if (nadd == freeze_idx) begin
      f = e;
      f.cen = 1'b0;
      q.push_back(f);
      q.push_back(f);
    end
    q.push_back(e);
    nadd++;
  endtask

  task automatic add_tail(input logic us);
    add(mk(8'h00, 0, us, 0, 0, 0, 0, 1, 1, 1));
    add(mk(8'h00, 0, us, 0, 0, 0, 0, 0, 0, 1));
  endtask

  task automatic build_psh(input logic [7:0] m, input logic us, input int waits);
    logic [7:0] rem = m;
    nadd = 0;
    for (int b = 7; b >= 0; b--) begin
      if (m[b]) begin
        for (int h = 0; h < ((b >= 4) ? 2 : 1); h++) begin
          add(mk(rem, h[0], us, 1, 0, 0, 0, 1, 0, 1));
          for (int w = 0; w < waits; w++) add(mk(rem, h[0], us, 0, 0, 1, 0, 1, 0, 0));
          add(mk(rem, h[0], us, 0, 0, 1, 0, 1, 0, 1));
        end
        rem[b] = 1'b0;
      end
    end
    add_tail(us);
  endtask

  task automatic build_pul(input logic [7:0] m, input logic us);
    logic [7:0] rem = m;
    nadd = 0;
    for (int b = 0; b < 8; b++) begin
      if (m[b]) begin
        for (int h = 0; h < ((b >= 4) ? 2 : 1); h++) begin
          logic hh;
          hh = (b >= 4) && (h == 0);
          add(mk(rem, hh, us, 0, 0, 0, 1, 1, 0, 1));
          add(mk(rem, hh, us, 0, 1, 0, 0, 1, 0, 1));
        end
        rem[b] = 1'b0;
      end
    end
    add_tail(us);
  endtask

  task automatic run(input string tag, input int lim);
    ent_t e;
    int   n = lim;
    while (q.size() > 0 && n > 0) begin
      @(posedge clk);
      #1;
      start_psh = 1'b0;
      start_pul = 1'b0;
      e = q.pop_front();
      chk(tag, {15'd0, obs},
          {15'd0, e.sel, e.hh, e.us, e.dec, e.pen, e.sb, e.we, e.rd, e.bsy, e.dn});
      mem_rdy   = e.rdy;
      cen       = e.cen;
      start_pul = noise & e.bsy;
      n--;
    end
  endtask

  task automatic launch(input logic psh, input logic pul, input logic [7:0] m, input logic us);
    mask      = m;
    ussel_in  = us;
    start_psh = psh;
    start_pul = pul;
    cen       = 1'b1;
    mem_rdy   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b1; start_psh = 1'b0; start_pul = 1'b0;
    ussel_in = 1'b0; mask = 8'h00; mem_rdy = 1'b1;
    #3;
    chk("reset_outputs", {15'd0, obs}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {15'd0, obs}, 32'd0);

    // A,B push; a pull request held high while busy must be ignored
    build_psh(8'h06, 1'b0, 0);
    noise = 1'b1;
    launch(1, 0, 8'h06, 1'b0);
    run("psh_06", 100);
    noise = 1'b0;

    // PC push with cen dropped for two cycles mid-operation
    freeze_idx = 2;
    build_psh(8'h80, 1'b0, 0);
    freeze_idx = -1;
    launch(1, 0, 8'h80, 1'b0);
    run("psh_80_cen", 100);

    build_pul(8'h11, 1'b1);
    launch(0, 1, 8'h11, 1'b1);
    run("pul_11_u", 100);

    build_psh(8'h02, 1'b0, 3);
    launch(1, 0, 8'h02, 1'b0);
    run("psh_02_wait", 100);

    nadd = 0;
    add_tail(1'b1);
    launch(1, 1, 8'h00, 1'b1);
    run("empty_both", 100);

    // abort a full push after three bytes
    build_psh(8'hFF, 1'b0, 0);
    launch(1, 0, 8'hFF, 1'b0);
    run("psh_ff_pre", 6);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {15'd0, obs}, 32'd0);
    q.delete();
    @(posedge clk); #1;
    chk("reset_held", {15'd0, obs}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_abort", {15'd0, obs}, 32'd0);

    build_pul(8'hFF, 1'b1);
    chk("pul_ff_len", q.size(), 32'd26);
    launch(0, 1, 8'hFF, 1'b1);
    run("pul_ff", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
